// File: rtl/fifo_access_arbiter.sv
// Round-robin arbiter sharing one FIFO pointer controller among NREQ requesters (IDLE->ISSUE->DONE).
// Optional FIFO_ARB_STATS_EN adds saturating stat_ops / stat_blocked counters.
module fifo_access_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_rw,
  input  logic            fifo_full,
  input  logic            fifo_empty,
  output logic            fifo_en,
  output logic            fifo_rw,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic [NREQ-1:0] ack,
  output logic            busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]     stat_ops,
  output logic [15:0]     stat_blocked
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [IDW:0] NREQ_W = NREQ[IDW:0];

  state_t          state_q, state_d;
  logic [IDW-1:0]  sel_q, sel_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic            fifo_en_q, fifo_en_d;
  logic            fifo_rw_q, fifo_rw_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [IDW-1:0]  pick;
  logic [IDW:0]    idx;
  logic [IDW:0]    rr_nxt;

  assign elig = req & ((req_rw & {NREQ{~fifo_full}}) | (~req_rw & {NREQ{~fifo_empty}}));

  // First eligible index at or after rr_q, wrapping explicitly since NREQ may not be a power of two.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_q} + k[IDW:0];
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && elig[idx[IDW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    rr_nxt = {1'b0, sel_q} + 1'b1;
    if (rr_nxt == NREQ_W) rr_nxt = '0;
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    fifo_en_d = 1'b0;
    fifo_rw_d = 1'b0;
    gnt_d     = '0;
    gnt_id_d  = gnt_id_q;
    ack_d     = '0;
    busy_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = ISSUE;
          sel_d       = pick;
          fifo_en_d   = 1'b1;
          fifo_rw_d   = req_rw[pick];
          gnt_d[pick] = 1'b1;
          gnt_id_d    = pick;
          busy_d      = 1'b1;
        end
      end
      ISSUE: begin
        state_d      = DONE;
        rr_d         = rr_nxt[IDW-1:0];
        ack_d[sel_q] = 1'b1;
        gnt_id_d     = sel_q;
        busy_d       = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      rr_q      <= '0;
      fifo_en_q <= 1'b0;
      fifo_rw_q <= 1'b0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      fifo_en_q <= fifo_en_d;
      fifo_rw_q <= fifo_rw_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign fifo_en = fifo_en_q;
  assign fifo_rw = fifo_rw_q;
  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign ack     = ack_q;
  assign busy    = busy_q;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_blocked_q, stat_blocked_d;

  always_comb begin
    stat_ops_d     = stat_ops_q;
    stat_blocked_d = stat_blocked_q;
    if (state_q == DONE && stat_ops_q != 16'hFFFF)
      stat_ops_d = stat_ops_q + 16'd1;
    if (state_q == IDLE && |req && !found && stat_blocked_q != 16'hFFFF)
      stat_blocked_d = stat_blocked_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_ops_q     <= '0;
      stat_blocked_q <= '0;
    end else begin
      stat_ops_q     <= stat_ops_d;
      stat_blocked_q <= stat_blocked_d;
    end
  end

  assign stat_ops     = stat_ops_q;
  assign stat_blocked = stat_blocked_q;
`endif

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Directed bench for fifo_access_arbiter with a behavioural 8-entry FIFO occupancy model.
module tb_fifo_access_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] req_rw;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_en;
  logic       fifo_rw;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic [3:0] ack;
  logic       busy;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_blocked;
  logic [15:0] blk_base;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_access_arbiter #(.NREQ(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_en(fifo_en), .fifo_rw(fifo_rw), .gnt(gnt), .gnt_id(gnt_id),
    .ack(ack), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .stat_ops(stat_ops), .stat_blocked(stat_blocked)
`endif
  );

  // Controller occupancy: the op latched at ISSUE lands at the end of DONE, so flags move one cycle later.
  int   cnt;
  logic pend_rw;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 0;
      pend_rw <= 1'b0;
    end else begin
      if (fifo_en) pend_rw <= fifo_rw;
      if (|ack) cnt <= pend_rw ? cnt + 1 : cnt - 1;
    end
  end
  assign fifo_full  = (cnt == 8);
  assign fifo_empty = (cnt == 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; req = '0; req_rw = '0;
    repeat (2) cyc();
    chk("rst_en", fifo_en, 0);
    chk("rst_rw", fifo_rw, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_id", gnt_id, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    cyc();

    // read on empty FIFO is skipped, write from req1 goes first
    req = 4'b0011; req_rw = 4'b0010;
    cyc(); chk("skip_gnt1", gnt, 4'b0010); chk("skip_rw1", fifo_rw, 1);
    cyc(); chk("skip_ack1", ack, 4'b0010); req = 4'b0001;
    cyc(); chk("skip_idle", busy, 0); chk("skip_nempty", fifo_empty, 0);
    cyc(); chk("skip_gnt0", gnt, 4'b0001); chk("skip_rw0", fifo_rw, 0); chk("skip_en0", fifo_en, 1);
    cyc(); chk("skip_ack0", ack, 4'b0001); req = '0;
    cyc(); chk("skip_empty", fifo_empty, 1);

    // single write latency
    req = 4'b0001; req_rw = 4'b0001;
    cyc();
    chk("lat_gnt", gnt, 4'b0001); chk("lat_en", fifo_en, 1); chk("lat_rw", fifo_rw, 1);
    chk("lat_busy", busy, 1); chk("lat_id", gnt_id, 0); chk("lat_ack_issue", ack, 0);
    cyc();
    chk("lat_ack", ack, 4'b0001); chk("lat_en_done", fifo_en, 0);
    chk("lat_gnt_done", gnt, 0); chk("lat_busy_done", busy, 1);
    req = '0;
    cyc(); chk("lat_nempty", fifo_empty, 0); chk("lat_busy_idle", busy, 0);

    // reset in the middle of ISSUE
    req = 4'b0001; req_rw = 4'b0001;
    cyc(); chk("mid_gnt", gnt, 4'b0001);
    reset = 1'b0; #1;
    chk("mid_en", fifo_en, 0); chk("mid_gnt0", gnt, 0);
    chk("mid_ack", ack, 0); chk("mid_busy", busy, 0);
    req = '0;
    cyc(); chk("mid_ack_a", ack, 0);
    reset = 1'b1;
    cyc(); chk("mid_ack_b", ack, 0); chk("mid_busy_b", busy, 0);
    cyc(); chk("mid_ack_c", ack, 0); chk("mid_empty", fifo_empty, 1);

    // all four writing: strict rotation starting at 0, one grant per 3 cycles
    req = 4'b1111; req_rw = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr_gnt", gnt, 32'(1 << (k % 4)));
      chk("rr_id", gnt_id, 32'(k % 4));
      cyc();
      chk("rr_ack", ack, 32'(1 << (k % 4)));
      if (k == 4) req = '0;
      cyc();
      chk("rr_idle", gnt, 0);
    end

    // top up to full with requester 0
    for (int k = 0; k < 3; k++) begin
      req = 4'b0001; req_rw = 4'b0001;
      cyc(); chk("fill_gnt", gnt, 4'b0001);
      cyc(); chk("fill_ack", ack, 4'b0001); req = '0;
      cyc();
    end
    chk("full_flag", fifo_full, 1);

`ifdef FIFO_ARB_STATS_EN
    blk_base = stat_blocked;
`endif
    req = 4'b0100; req_rw = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      cyc(); chk("full_block", gnt, 0); chk("full_busy", busy, 0);
    end
`ifdef FIFO_ARB_STATS_EN
    chk("stat_blocked", stat_blocked, 32'(blk_base + 16'd4));
`endif

    // a read unblocks the waiting write
    req = 4'b1100;
    cyc(); chk("rd_gnt", gnt, 4'b1000); chk("rd_rw", fifo_rw, 0);
    cyc(); chk("rd_ack", ack, 4'b1000); req = 4'b0100;
    cyc(); chk("rd_idle", gnt, 0); chk("rd_notfull", fifo_full, 0);
    cyc(); chk("wr_gnt", gnt, 4'b0100); chk("wr_rw", fifo_rw, 1);
    req = '0;  // requester drops during ISSUE
    cyc(); chk("drop_ack", ack, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      cyc(); chk("drop_nogrant", gnt, 0); chk("drop_busy", busy, 0);
    end
`ifdef FIFO_ARB_STATS_EN
    chk("stat_ops", stat_ops, 10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
